mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 120 ++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of a single fixed-latency memory.
// One transaction is outstanding at a time; ties are broken round-robin.
module mem_arbiter #(
    parameter int MEM_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ready,
    output logic [31:0] i_rdata,

    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ready,
    output logic [31:0] d_rdata,

    output logic        m_en,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,

    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        DONE
    } state_t;

    // Counter is 4 bits wide, so MEM_LATENCY must stay within 1..15.
    localparam logic [3:0] CNT_LOAD = 4'(MEM_LATENCY - 1);

    state_t     state;
    logic [3:0] cnt;
    logic       owner_d;
    logic       owner_store;
    logic       last_d;
    logic       grant_d;

    // On a tie the port that was not served last wins.
    always_comb begin
        grant_d = d_req;
        if (i_req && d_req) begin
            grant_d = !last_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            owner_d     <= 1'b0;
            owner_store <= 1'b0;
            last_d      <= 1'b1;
            m_en        <= 1'b0;
            m_we        <= 1'b0;
            m_addr      <= '0;
            m_wdata     <= '0;
            i_ready     <= 1'b0;
            d_ready     <= 1'b0;
            i_rdata     <= '0;
            d_rdata     <= '0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_req || d_req) begin
                        owner_d     <= grant_d;
                        owner_store <= grant_d && d_we;
                        m_addr      <= grant_d ? d_addr : i_addr;
                        m_wdata     <= grant_d ? d_wdata : 32'h0;
                        m_we        <= grant_d && d_we;
                        m_en        <= 1'b1;
                        busy        <= 1'b1;
                        state       <= ACCESS;
                    end
                end

                ACCESS: begin
                    m_en  <= 1'b0;
                    m_we  <= 1'b0;
                    cnt   <= CNT_LOAD;
                    state <= WAIT;
                end

                // Memory data is valid in the cycle the counter reaches zero.
                WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        if (!owner_d) begin
                            i_rdata <= m_rdata;
                        end else if (!owner_store) begin
                            d_rdata <= m_rdata;
                        end
                        i_ready <= !owner_d;
                        d_ready <= owner_d;
                        state   <= DONE;
                    end
                end

                DONE: begin
                    i_ready <= 1'b0;
                    d_ready <= 1'b0;
                    busy    <= 1'b0;
                    last_d  <= owner_d;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule
